univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal register: generalises the single-bit D flip-flop to a
//   WIDTH-bit register with hold/load/shift/rotate/clear modes and serial I/O.
//   Adds a burst engine that performs N back-to-back shifts/rotates with busy/done
//   status. Sits behind the tt_um top-level pin mapping as a reusable datapath block.
// PARAMETERS
//   WIDTH  8  register width in bits; WIDTH >= 2
//   CNT_W  4  width of the burst count; max burst = 2**CNT_W-1
// PORTS
//   clk      in   1      single clock; all state updates on posedge
//   rst_n    in   1      asynchronous, active-low reset
//   en       in   1      single-step enable for mode ops (ignored unless IDLE)
//   mode     in   3      op select (encodings below)
//   d        in   WIDTH  parallel load data
//   sin_r    in   1      serial in, enters bit 0 on SHL
//   sin_l    in   1      serial in, enters bit WIDTH-1 on SHR
//   start    in   1      burst request; op=mode, length=cnt
//   cnt      in   CNT_W  burst length N
//   q        out  WIDTH  register contents
//   sout_msb out  1      q[WIDTH-1]
//   sout_lsb out  1      q[0]
//   busy     out  1      high while burst in RUN
//   done     out  1      one-cycle pulse at burst completion
//   parity   out  1      XOR of q (USR_PARITY_EN only, else tied 0)
// BEHAVIOUR
//   - Reset: q=0, busy=0, done=0, parity=0, FSM=IDLE; reset mid-burst aborts, no done.
//   - mode: 000 HOLD, 001 LOAD q<=d, 010 SHL q<={q[W-2:0],sin_r},
//     011 SHR q<={sin_l,q[W-1:1]}, 100 ROTL, 101 ROTR, 110 CLEAR q<=0, 111 = HOLD.
//   - Single step: IDLE & en & !start -> op applied at next edge (1-cycle latency).
//   - FSM IDLE->RUN->DONE->IDLE. IDLE & start & mode in 010..101: latch op, ctr<=cnt;
//     enter RUN if cnt!=0, DONE if cnt==0. start with any other mode: ignored
//     (no en op that cycle either); start has priority over en.
//   - RUN: one latched op per edge, ctr decrements; edge with ctr==1 -> DONE.
//     Start accepted at edge t => q updates at edges t+1..t+N; done=1 for cycle
//     after edge t+N; back in IDLE after edge t+N+1. busy=1 exactly in RUN.
//   - sin_l/sin_r sampled live each RUN cycle; mode/cnt/en/start ignored outside IDLE.
//   - DONE: q holds; new start only accepted once IDLE again.
//   - sout_msb/sout_lsb combinational from q; no wrap hazards (rotate closes ring).
// CONFIGURATION
//   USR_PARITY_EN defined: parity register updated each edge to ^q_next (matches q
//   in same cycle), reset 0. Undefined: parity tied 0, no parity flop synthesised.
// STRUCTURE
//   usr_pkg: mode encodings (MODE_HOLD..MODE_CLEAR) as localparam/enum, FSM state
//   typedef (ST_IDLE/ST_RUN/ST_DONE). Sub-module usr_burst_ctrl: FSM + down-counter,
//   outputs busy/done/step/op_latched; top holds the datapath mux and q register.
// TESTING
//   1 reset -> q=0x00,busy=0,done=0; en=1 LOAD d=0xA5 -> q=0xA5; en=0 LOAD 0x3C -> q=0xA5.
//   2 q=0x81: en ROTL -> 0x03; then ROTR -> 0x81; CLEAR -> 0x00; mode 111 -> hold.
//   3 q=0x00, SHL sin_r=1 x4 -> 0x0F; q=0xF0, SHR sin_l=0 x1 -> 0x78, sout_lsb=0.
//   4 q=0x01, start ROTR cnt=3 -> busy 3 cycles, q=0x80,0x40,0x20, done 1 cycle;
//     start during busy ignored, q ends 0x20.
//   5 start cnt=0 -> busy never 1, done next cycle, q unchanged; start mode=LOAD ignored.
//   6 burst SHL cnt=10, rst_n low at step 4 -> q=0,busy=0, no done; with
//     USR_PARITY_EN, q=0x07 -> parity=1, q=0x03 -> parity=0.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// usr_pkg: shared definitions for the universal shift register.
//   mode_e  : operation encodings driven on the mode port
//   state_e : burst controller FSM states
//   is_burst_mode() : true for the shift/rotate ops that a burst may repeat
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD     = 3'b000,
    MODE_LOAD     = 3'b001,
    MODE_SHL      = 3'b010,
    MODE_SHR      = 3'b011,
    MODE_ROTL     = 3'b100,
    MODE_ROTR     = 3'b101,
    MODE_CLEAR    = 3'b110,
    MODE_HOLD_ALT = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_burst_mode(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bundle of the universal shift register.
//   master : drives en, mode, d, sin_r, sin_l, start, cnt; observes outputs
//   slave  : the register itself; drives q, sout_msb, sout_lsb, busy, done, parity
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;
  logic             parity;

  modport master (
    output en, mode, d, sin_r, sin_l, start, cnt,
    input  q, sout_msb, sout_lsb, busy, done, parity
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l, start, cnt,
    output q, sout_msb, sout_lsb, busy, done, parity
  );
endinterface

// File: rtl/univ_shift_reg_burst_ctrl.sv
// usr_burst_ctrl: burst FSM (IDLE -> RUN -> DONE -> IDLE) plus down-counter.
//   Inputs : clk, rst_n (async, active low), en, start, mode, cnt
//   Outputs: busy (RUN), done (DONE pulse), step (apply op this edge),
//            op (operation to apply when step is high)
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  mode_e            mode,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             step,
  output mode_e            op
);

  state_e           state_q, state_d;
  mode_e            op_q, op_d;
  logic [CNT_W-1:0] ctr_q, ctr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MODE_HOLD;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctr_d   = ctr_q;
    step    = 1'b0;
    op      = op_q;
    unique case (state_q)
      ST_IDLE: begin
        // start wins over en; a start with a non-shift mode suppresses both
        if (start) begin
          if (is_burst_mode(mode)) begin
            op_d    = mode;
            ctr_d   = cnt;
            state_d = (cnt != '0) ? ST_RUN : ST_DONE;
          end
        end else if (en) begin
          step = 1'b1;
          op   = mode;
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        ctr_d = ctr_q - CNT_W'(1);
        if (ctr_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register (hold/load/shift/rotate/clear)
// with a burst engine that repeats a shift/rotate N times.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): en, mode, d, sin_r, sin_l, start, cnt in;
//                q, sout_msb, sout_lsb, busy, done, parity out
// Optional feature macro USR_PARITY_EN: registered XOR of q on bus.parity;
// when undefined parity is tied low.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  univ_shift_reg_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_next;
  logic             step;
  mode_e            op;
  mode_e            mode_in;

  assign mode_in = mode_e'(bus.mode);

  usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .start (bus.start),
    .mode  (mode_in),
    .cnt   (bus.cnt),
    .busy  (bus.busy),
    .done  (bus.done),
    .step  (step),
    .op    (op)
  );

  always_comb begin
    q_next = q_q;
    if (step) begin
      unique case (op)
        MODE_LOAD:  q_next = bus.d;
        MODE_SHL:   q_next = {q_q[WIDTH-2:0], bus.sin_r};
        MODE_SHR:   q_next = {bus.sin_l, q_q[WIDTH-1:1]};
        MODE_ROTL:  q_next = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROTR:  q_next = {q_q[0], q_q[WIDTH-1:1]};
        MODE_CLEAR: q_next = '0;
        default:    q_next = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_next;
    end
  end

  assign bus.q        = q_q;
  assign bus.sout_msb = q_q[WIDTH-1];
  assign bus.sout_lsb = q_q[0];

`ifdef USR_PARITY_EN
  // computed from q_next so parity lines up with q in the same cycle
  logic parity_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^q_next;
    end
  end
  assign bus.parity = parity_q;
`else
  assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4): directed table,
// hand-written burst/reset sequences, and randomized ops against a reference model.
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_ROTL  = 3'd4;
  localparam logic [2:0] M_ROTR  = 3'd5;
  localparam logic [2:0] M_CLEAR = 3'd6;
  localparam logic [2:0] M_HOLD2 = 3'd7;

`ifdef USR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] qm;

  typedef struct {
    logic       en;
    logic       start;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sr;
    logic       sl;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, ".q"},        32'(bus.q),        32'(qm));
    chk({tag, ".sout_msb"}, 32'(bus.sout_msb), 32'(qm[7]));
    chk({tag, ".sout_lsb"}, 32'(bus.sout_lsb), 32'(qm[0]));
    chk({tag, ".busy"},     32'(bus.busy),     32'(exp_busy));
    chk({tag, ".done"},     32'(bus.done),     32'(exp_done));
    chk({tag, ".parity"},   32'(bus.parity),   32'(PAR_EN ? ^qm : 1'b0));
  endtask

  // Reference: ops expressed as arithmetic on the unsigned register value.
  function automatic logic [7:0] ref_op(input logic [2:0] m, input logic [7:0] q,
                                        input logic [7:0] d, input logic sr, input logic sl);
    int unsigned v;
    v = 32'(q);
    case (m)
      M_LOAD:  return d;
      M_SHL:   return 8'(((v * 2) + 32'(sr)) % 256);
      M_SHR:   return 8'((v / 2) + (sl ? 128 : 0));
      M_ROTL:  return 8'(((v * 2) % 256) + (v / 128));
      M_ROTR:  return 8'((v / 2) + ((v % 2) * 128));
      M_CLEAR: return 8'h00;
      default: return q;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.en = 1'b0; bus.start = 1'b0; bus.mode = M_HOLD; bus.cnt = 4'd0;
    bus.d = 8'h00; bus.sin_r = 1'b0; bus.sin_l = 1'b0;
  endtask

  task automatic single(input logic [2:0] m, input logic [7:0] d, input logic sr,
                        input logic sl, input logic en);
    bus.en = en; bus.start = 1'b0; bus.mode = m; bus.d = d;
    bus.sin_r = sr; bus.sin_l = sl; bus.cnt = 4'($urandom);
    tick();
    if (en) qm = ref_op(m, qm, d, sr, sl);
    chk_outs("single", 1'b0, 1'b0);
  endtask

  task automatic run_burst(input logic [2:0] m, input logic [3:0] n);
    logic sr, sl;
    chk_outs("pre_burst", 1'b0, 1'b0);
    bus.start = 1'b1; bus.mode = m; bus.cnt = n;
    bus.en = 1'($urandom); bus.d = 8'($urandom);
    tick();
    for (int i = 0; i < int'(n); i++) begin
      chk_outs("burst_run", 1'b1, 1'b0);
      sr = 1'($urandom); sl = 1'($urandom);
      bus.sin_r = sr; bus.sin_l = sl;
      // control inputs must be ignored while running
      bus.en = 1'($urandom); bus.start = 1'($urandom); bus.mode = 3'($urandom);
      bus.cnt = 4'($urandom); bus.d = 8'($urandom);
      tick();
      qm = ref_op(m, qm, 8'h00, sr, sl);
    end
    chk_outs("burst_done", 1'b0, 1'b1);
    // start/en during DONE must be ignored
    bus.start = 1'b1; bus.mode = M_SHL; bus.cnt = 4'd5; bus.en = 1'b1;
    tick();
    chk_outs("after_done", 1'b0, 1'b0);
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] nb_modes [4];
    nb_modes = '{M_HOLD, M_LOAD, M_CLEAR, M_HOLD2};

    // reset state
    rst_n = 1'b0;
    drive_idle();
    #12;
    qm = 8'h00;
    chk_outs("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed single-step table
    vecs.push_back('{1'b1, 1'b0, M_LOAD,  8'hA5, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 1'b0, M_LOAD,  8'h3C, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 1'b0, M_LOAD,  8'h81, 1'b0, 1'b0, 8'h81});
    vecs.push_back('{1'b1, 1'b0, M_ROTL,  8'h00, 1'b0, 1'b0, 8'h03});
    vecs.push_back('{1'b1, 1'b0, M_ROTR,  8'h00, 1'b0, 1'b0, 8'h81});
    vecs.push_back('{1'b1, 1'b0, M_CLEAR, 8'hFF, 1'b1, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 1'b0, M_LOAD,  8'h5A, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{1'b1, 1'b0, M_HOLD2, 8'hFF, 1'b1, 1'b1, 8'h5A});
    vecs.push_back('{1'b1, 1'b0, M_HOLD,  8'hFF, 1'b1, 1'b1, 8'h5A});
    vecs.push_back('{1'b1, 1'b0, M_LOAD,  8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, M_SHL,   8'h00, 1'b1, 1'b0, 8'h01});
    vecs.push_back('{1'b1, 1'b0, M_SHL,   8'h00, 1'b1, 1'b0, 8'h03});
    vecs.push_back('{1'b1, 1'b0, M_SHL,   8'h00, 1'b1, 1'b0, 8'h07});
    vecs.push_back('{1'b1, 1'b0, M_SHL,   8'h00, 1'b1, 1'b0, 8'h0F});
    vecs.push_back('{1'b1, 1'b0, M_LOAD,  8'hF0, 1'b0, 1'b0, 8'hF0});
    vecs.push_back('{1'b1, 1'b0, M_SHR,   8'h00, 1'b1, 1'b0, 8'h78});
    vecs.push_back('{1'b1, 1'b1, M_LOAD,  8'hFF, 1'b0, 1'b0, 8'h78});
    vecs.push_back('{1'b1, 1'b0, M_LOAD,  8'h07, 1'b0, 1'b0, 8'h07});
    vecs.push_back('{1'b1, 1'b0, M_LOAD,  8'h03, 1'b0, 1'b0, 8'h03});

    foreach (vecs[i]) begin
      bus.en = vecs[i].en; bus.start = vecs[i].start; bus.mode = vecs[i].mode;
      bus.d = vecs[i].d; bus.sin_r = vecs[i].sr; bus.sin_l = vecs[i].sl; bus.cnt = 4'd3;
      tick();
      qm = vecs[i].exp_q;
      chk_outs($sformatf("vec%0d", i), 1'b0, 1'b0);
    end
    drive_idle();

    // burst ROTR x3 from 0x01
    single(M_LOAD, 8'h01, 1'b0, 1'b0, 1'b1);
    run_burst(M_ROTR, 4'd3);
    chk("rotr_burst_end", 32'(bus.q), 32'h20);

    // zero-length burst
    run_burst(M_SHL, 4'd0);
    chk("cnt0_q_unchanged", 32'(bus.q), 32'h20);

    // max-length burst
    single(M_LOAD, 8'hC3, 1'b0, 1'b0, 1'b1);
    run_burst(M_ROTL, 4'd15);

    // reset in the middle of a burst
    single(M_LOAD, 8'h55, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1; bus.mode = M_SHL; bus.cnt = 4'd10;
    tick();
    bus.start = 1'b0; bus.sin_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      qm = ref_op(M_SHL, qm, 8'h00, 1'b1, 1'b0);
      chk_outs("pre_abort", 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    qm = 8'h00;
    chk_outs("abort_rst", 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_outs("post_abort", 1'b0, 1'b0);
    end

    // randomized mix of single steps and bursts
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 4) == 0) begin
          // start with a non-shift mode: nothing happens even with en high
          bus.en = 1'($urandom); bus.start = 1'b1;
          bus.mode = nb_modes[$urandom_range(0, 3)];
          bus.d = 8'($urandom); bus.cnt = 4'($urandom);
          bus.sin_r = 1'($urandom); bus.sin_l = 1'($urandom);
          tick();
          chk_outs("rand_ign_start", 1'b0, 1'b0);
          drive_idle();
        end else begin
          single(3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
      end else begin
        run_burst(3'($urandom_range(2, 5)), 4'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
